half_adder: RTL and testbench
=============================

// Module: half_adder
// PURPOSE
//   Registered, WIDTH-lane bitwise half adder: per lane, sum = a XOR b, carry = a AND b.
//   Operands enter through a valid/ready input port. Results leave through a
//   2-entry FIFO output stage, so the block sustains one operation per cycle under backpressure.
//   Each result also carries a popcount of its carry lanes.
//   Leaf arithmetic block. WIDTH=1 is the classic single-bit half adder.
// PARAMETERS
//   WIDTH   1                   number of independent half-adder lanes (>=1)
//   CW      $clog2(WIDTH+1)     width of carry_cnt (derived; do not override)
// PORTS
//   clk        input   1      rising-edge clock
//   rst_n      input   1      reset, asynchronous assert, active-low
//   a          input   WIDTH  operand A, one bit per lane
//   b          input   WIDTH  operand B, one bit per lane
//   in_valid   input   1      a/b hold a valid operation
//   in_ready   output  1      block can accept an operation this cycle
//   sum        output  WIDTH  per-lane a^b of the head result
//   carry      output  WIDTH  per-lane a&b of the head result
//   carry_cnt  output  CW     number of 1 bits in carry (head result)
//   out_valid  output  1      sum/carry/carry_cnt valid
//   out_ready  input   1      consumer takes the head result this cycle
// BEHAVIOUR
//   - One clock (clk), reset asynchronous and active-low (rst_n); all state resets asynchronously.
//   - Reset (rst_n=0): FIFO empty.
//     Outputs: out_valid=0, sum=0, carry=0, carry_cnt=0, in_ready=1.
//     Reset mid-operation discards every entry immediately.
//   - Accept: in_valid && in_ready at a clk edge.
//     Computes sum=a^b, carry=a&b and carry_cnt=popcount(a&b) combinationally.
//     These values are written into the FIFO at that edge.
//   - Pop: out_valid && out_ready at a clk edge removes the head entry.
//   - Latency: a result accepted at edge N is visible on the outputs after edge N
//     when the FIFO was empty. Otherwise it appears behind older entries, in FIFO order.
//   - in_ready = (occupancy < 2). It is a registered-state function and never depends on out_ready.
//   - out_valid = (occupancy > 0).
//     - While out_valid=1, sum/carry/carry_cnt hold the head entry.
//     - They stay stable until the head is popped.
//   - Simultaneous accept and pop:
//     - occupancy 1: occupancy stays 1; the new entry becomes head.
//     - occupancy 0: pop is impossible (out_valid=0); accept only.
//     - occupancy 2: accept is impossible (in_ready=0); pop only.
//   - While out_valid=0, outputs hold the last popped values (0 after reset).
//     Consumers ignore them.
//   - in_valid=1 with in_ready=0: no state change; producer holds a/b.
//   - Lanes are fully independent; there is no carry propagation between lanes.
//   - carry_cnt range is 0..WIDTH. CW is sized so WIDTH fits with no overflow.
// TESTING
//   1. WIDTH=1, out_ready=1. Apply a,b = 00,01,10,11, one per 100 ns, in_valid=1.
//      -> sum,carry = 00,10,10,01; carry_cnt = 0,0,0,1.
//   2. WIDTH=8, a=8'hF0, b=8'h3C, single op.
//      -> sum=8'hCC, carry=8'h30, carry_cnt=2, out_valid one cycle after accept.
//   3. WIDTH=8, out_ready=0, three back-to-back ops.
//      -> in_ready drops after 2 accepts.
//      -> Raise out_ready: results pop in order and in_ready returns to 1.
//   4. Steady stream, in_valid=1 and out_ready=1 every cycle.
//      -> one result per cycle, no bubbles after the first.
//   5. Assert rst_n=0 with 2 entries queued.
//      -> out_valid=0, in_ready=1, sum=carry=0 immediately, without waiting for clk.
//   6. WIDTH=8, a=b=8'hFF.
//      -> sum=0, carry=8'hFF, carry_cnt=8.

Source files
------------

// File: rtl/half_adder.sv
// half_adder: registered WIDTH-lane half adder with valid/ready input and 2-entry output FIFO
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [CW-1:0]    carry_cnt,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int EW = 2 * WIDTH + CW;
   logic [WIDTH-1:0] c;
   logic [CW-1:0]    cnt;
   logic [EW-1:0]    head, tail, nw;
   logic [1:0]       occ;
   logic             acc, pop;
   assign c         = a & b;
   assign nw        = {a ^ b, c, cnt};
   assign in_ready  = occ != 2'd2;
   assign out_valid = occ != 2'd0;
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign {sum, carry, carry_cnt} = head;
   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(c[i]);
   end
   // head keeps the last popped entry when the FIFO drains, so outputs hold stale values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ  <= '0;
         head <= '0;
         tail <= '0;
      end else begin
         occ <= occ + 2'(acc) - 2'(pop);
         if (acc && (occ == 2'd0 || pop)) head <= nw;
         else if (pop && occ == 2'd2) head <= tail;
         if (acc && occ == 2'd1 && !pop) tail <= nw;
      end
   end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench for half_adder (WIDTH=8 main instance, WIDTH=1 classic instance)
module tb_half_adder;
   logic       clk = 0, rst_n = 0;
   logic [7:0] a = 0, b = 0, sum, carry;
   logic [3:0] carry_cnt;
   logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
   logic       a1 = 0, b1 = 0, v1 = 0, r1, sum1, carry1, cnt1, ov1;
   logic [19:0] q[$];
   int passed = 0, total = 0, pops = 0;

   half_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .carry(carry), .carry_cnt(carry_cnt), .out_valid(out_valid), .out_ready(out_ready)
   );
   half_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .in_ready(r1),
      .sum(sum1), .carry(carry1), .carry_cnt(cnt1), .out_valid(ov1), .out_ready(1'b1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Expected entries are pushed on accept and compared on pop, both decided just before the edge.
   always @(negedge clk) begin
      logic [19:0] e;
      if (rst_n) begin
         check("out_valid", 32'(out_valid), 32'(q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(q.size() < 2));
         if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) check("pop_empty", 32'(out_valid), 0);
            else begin
               e = q.pop_front();
               check("sum", 32'(sum), 32'(e[19:12]));
               check("carry", 32'(carry), 32'(e[11:4]));
               check("carry_cnt", 32'(carry_cnt), 32'(e[3:0]));
            end
         end
         if (in_valid && in_ready) q.push_back({a ^ b, a & b, 4'($countones(a & b))});
      end
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y);
      bit ok = 0;
      a = x; b = y; in_valid = 1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check("drain", q.size(), 0);
   endtask

   initial begin
      logic [3:0] s_tab = 4'b0110, c_tab = 4'b1000;
      int p0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_sum", 32'(sum), 0);
      check("rst_carry", 32'(carry), 0);
      check("rst_cnt", 32'(carry_cnt), 0);
      #11 rst_n = 1;
      @(posedge clk); #1;
      // classic single-bit half adder, one op per 100 ns
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0]; v1 = 1;
         @(posedge clk); #1;
         v1 = 0;
         check("w1_valid", 32'(ov1), 1);
         check("w1_sum", 32'(sum1), 32'(s_tab[i]));
         check("w1_carry", 32'(carry1), 32'(c_tab[i]));
         check("w1_cnt", 32'(cnt1), 32'(c_tab[i]));
         repeat (9) @(posedge clk);
         #1;
      end
      // single op, result one cycle after accept
      send(8'hF0, 8'h3C); in_valid = 0;
      check("t2_valid", 32'(out_valid), 1);
      check("t2_sum", 32'(sum), 32'h CC);
      check("t2_carry", 32'(carry), 32'h30);
      check("t2_cnt", 32'(carry_cnt), 2);
      out_ready = 1; drain(); out_ready = 0;
      // backpressure: full after two accepts
      send(8'h11, 8'h22); send(8'h33, 8'h44);
      a = 8'h55; b = 8'h66;
      @(negedge clk); check("t3_full", 32'(in_ready), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1;
      send(8'h55, 8'h66); in_valid = 0;
      drain();
      @(negedge clk); check("t3_ready_back", 32'(in_ready), 1);
      @(posedge clk); #1;
      // steady stream
      p0 = pops;
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom); b = 8'($urandom); in_valid = 1;
         @(posedge clk); #1;
      end
      in_valid = 0;
      @(posedge clk); #1;
      check("t4_pops", pops - p0, 10);
      // all ones
      out_ready = 0;
      send(8'hFF, 8'hFF); in_valid = 0;
      check("t6_sum", 32'(sum), 0);
      check("t6_carry", 32'(carry), 32'hFF);
      check("t6_cnt", 32'(carry_cnt), 8);
      out_ready = 1; drain(); out_ready = 0;
      // asynchronous reset with two entries queued
      send(8'hA5, 8'h0F); send(8'h5A, 8'hF0); in_valid = 0;
      #2 rst_n = 0;
      #1;
      check("t5_out_valid", 32'(out_valid), 0);
      check("t5_in_ready", 32'(in_ready), 1);
      check("t5_sum", 32'(sum), 0);
      check("t5_carry", 32'(carry), 0);
      check("t5_cnt", 32'(carry_cnt), 0);
      q.delete();
      @(negedge clk); #2 rst_n = 1;
      @(posedge clk); #1;
      out_ready = 1;
      send(8'h0F, 8'hFF); in_valid = 0;
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
